// File: rtl/base_pkg.sv
// -----------------------------------------------------------------------------
// base_pkg -- shared types and helpers for the base_rrarb arbiter.
//   lock_state_t : packet-lock state (IDLE, LOCK), used when BASE_RRARB_LOCK_EN
//                  is defined.
//   sel_width()  : width of a requester index, max(1, clog2(n)).
// -----------------------------------------------------------------------------
package base_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } lock_state_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/base_rrarb_pick.sv
// -----------------------------------------------------------------------------
// base_rrarb_pick -- rotating-priority pick.
// Finds the first set request at or above i_ptr, wrapping from ways-1 to 0.
// Purely combinational.
//   i_req   [ways-1:0] : request vector
//   i_ptr   [sw-1:0]   : index with highest priority this cycle
//   o_grant [ways-1:0] : one-hot grant (all zero when no request)
//   o_idx   [sw-1:0]   : index of the granted request (0 when none)
//   o_any              : a grant was issued
// -----------------------------------------------------------------------------
module base_rrarb_pick
  import base_pkg::*;
#(
  parameter int ways = 4,
  parameter int sw   = sel_width(ways)
) (
  input  logic [ways-1:0] i_req,
  input  logic [sw-1:0]   i_ptr,
  output logic [ways-1:0] o_grant,
  output logic [sw-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    int j;
    // NOTE: every output gets a default before the search so no path through
    // the loop leaves a value unassigned, which would infer a latch.
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    j       = 0;
    for (int k = 0; k < ways; k++) begin
      j = int'(i_ptr) + k;
      if (j >= ways) j = j - ways;
      if (!o_any && i_req[j]) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = sw'(j);
      end
    end
  end

endmodule

// File: rtl/base_rrarb.sv
// -----------------------------------------------------------------------------
// base_rrarb -- round-robin arbiter of `ways` valid/ready streams into one
// registered output stage.
//   clk, reset         : rising-edge clock, asynchronous active-high reset
//   din_v/din_r/din_e  : per-requester valid, ready, end-of-packet
//   din_d              : requester i data at [i*width +: width]
//   dout_v/dout_r      : output valid / consumer ready
//   dout_d/dout_e      : output data and end flag
//   dout_s             : index of the requester that sourced the output beat
// Configuration macro: BASE_RRARB_LOCK_EN -- when defined, once a requester
// starts a packet (beat with din_e=0) it keeps the grant until its din_e=1
// beat; otherwise arbitration happens on every beat.
// -----------------------------------------------------------------------------
module base_rrarb
  import base_pkg::*;
#(
  parameter int ways  = 4,
  parameter int width = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ways-1:0]           din_v,
  output logic [ways-1:0]           din_r,
  input  logic [ways*width-1:0]     din_d,
  input  logic [ways-1:0]           din_e,
  output logic                      dout_v,
  input  logic                      dout_r,
  output logic [width-1:0]          dout_d,
  output logic                      dout_e,
  output logic [sel_width(ways)-1:0] dout_s
);

  localparam int SW = sel_width(ways);

  logic [SW-1:0]    r_ptr;
  logic             r_dout_v;
  logic [width-1:0] r_dout_d;
  logic             r_dout_e;
  logic [SW-1:0]    r_dout_s;

  logic [ways-1:0]  w_pick_grant;
  logic [SW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic [ways-1:0]  w_grant;
  logic [SW-1:0]    w_idx;
  logic             w_any;
  logic             w_load;
  logic             w_acc;
  logic             w_end;
  logic [width-1:0] w_sel_d;
  logic             w_sel_e;
  logic [SW-1:0]    w_ptr_nxt;

  base_rrarb_pick #(
    .ways (ways),
    .sw   (SW)
  ) u_pick (
    .i_req   (din_v),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

`ifdef BASE_RRARB_LOCK_EN
  lock_state_t   r_state;
  lock_state_t   w_state_nxt;
  logic [SW-1:0] r_owner;
  logic [SW-1:0] w_owner_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      IDLE: if (w_acc && !w_sel_e) begin
        w_state_nxt = LOCK;
        w_owner_nxt = w_idx;
      end
      LOCK: if (w_acc && w_sel_e) w_state_nxt = IDLE;
    endcase
  end

  // While locked only the owner may be granted; its din_v low is a bubble.
  always_comb begin
    w_grant = w_pick_grant;
    w_idx   = w_pick_idx;
    w_any   = w_pick_any;
    if (r_state == LOCK) begin
      for (int i = 0; i < ways; i++) begin
        w_grant[i] = din_v[i] && (int'(r_owner) == i);
      end
      w_idx = r_owner;
      w_any = |w_grant;
    end
  end

  assign w_end = w_sel_e;
`else
  assign w_grant = w_pick_grant;
  assign w_idx   = w_pick_idx;
  assign w_any   = w_pick_any;
  assign w_end   = 1'b1;
`endif

  // The output register takes a new beat when empty or draining this cycle.
  assign w_load = ~r_dout_v | dout_r;
  assign w_acc  = w_any & w_load;
  assign din_r  = w_grant & {ways{w_load}};

  // Grant is one-hot, so an OR-mux of the granted lane is sufficient.
  always_comb begin
    w_sel_d = '0;
    w_sel_e = 1'b0;
    for (int i = 0; i < ways; i++) begin
      if (w_grant[i]) begin
        w_sel_d = din_d[i*width +: width];
        w_sel_e = din_e[i];
      end
    end
  end

  assign w_ptr_nxt = (int'(w_idx) == ways - 1) ? '0 : w_idx + SW'(1);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order. The data
  // registers are reset as well so the output reads all-zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr    <= '0;
      r_dout_v <= 1'b0;
      r_dout_d <= '0;
      r_dout_e <= 1'b0;
      r_dout_s <= '0;
    end else begin
      if (w_acc && w_end) r_ptr <= w_ptr_nxt;
      if (w_load) begin
        r_dout_v <= w_acc;
        if (w_acc) begin
          r_dout_d <= w_sel_d;
          r_dout_e <= w_sel_e;
          r_dout_s <= w_idx;
        end
      end
    end
  end

  assign dout_v = r_dout_v;
  assign dout_d = r_dout_d;
  assign dout_e = r_dout_e;
  assign dout_s = r_dout_s;

endmodule

// File: tb/tb_base_rrarb.sv
// -----------------------------------------------------------------------------
// tb_base_rrarb -- self-checking bench for base_rrarb (ways=4, width=8).
// A reference model steps once per cycle from the arbitration rules; accepted
// beats are queued as expected outputs and a monitor compares them against
// the DUT output whenever it presents a beat. Directed scenarios cover the
// rotation order, single requester, back-pressure, packet locking and reset.
// -----------------------------------------------------------------------------
module tb_base_rrarb;

  localparam int WAYS = 4;
  localparam int W    = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [WAYS-1:0] din_v = '0;
  logic [WAYS-1:0] din_r;
  logic [WAYS*W-1:0] din_d = '0;
  logic [WAYS-1:0] din_e = '0;
  logic            dout_v;
  logic            dout_r = 1'b0;
  logic [W-1:0]    dout_d;
  logic            dout_e;
  logic [1:0]      dout_s;

  base_rrarb #(.ways(WAYS), .width(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .din_v  (din_v),
    .din_r  (din_r),
    .din_d  (din_d),
    .din_e  (din_e),
    .dout_v (dout_v),
    .dout_r (dout_r),
    .dout_d (dout_d),
    .dout_e (dout_e),
    .dout_s (dout_s)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected beats, packed {s[1:0], e, d[7:0]}.
  logic [10:0] q[$];
  logic [10:0] pend;
  bit          pend_ok = 0;

  // Reference model state.
  int m_ptr  = 0;
  bit m_full = 0;
`ifdef BASE_RRARB_LOCK_EN
  bit m_lock  = 0;
  int m_owner = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One model step using the inputs currently applied.
  task automatic model_step();
    int g;
    bit load;
    bit acc;
    bit fin;
    logic [3:0] exp_r;
    g = -1;
`ifdef BASE_RRARB_LOCK_EN
    if (m_lock) begin
      if (din_v[m_owner]) g = m_owner;
    end else
`endif
    for (int k = 0; k < WAYS; k++) begin
      int j = (m_ptr + k) % WAYS;
      if (g < 0 && din_v[j]) g = j;
    end
    load  = !m_full || dout_r;
    acc   = (g >= 0) && load;
    exp_r = acc ? 4'(1 << g) : 4'b0000;
    check("din_r", 32'(din_r), 32'(exp_r));
    if (acc) begin
      pend    = {2'(g), din_e[g], din_d[g*W +: W]};
      pend_ok = 1;
`ifdef BASE_RRARB_LOCK_EN
      fin = din_e[g];
      if (!m_lock && !din_e[g]) begin
        m_lock  = 1;
        m_owner = g;
      end else if (m_lock && din_e[g]) begin
        m_lock = 0;
      end
`else
      fin = 1;
`endif
      if (fin) m_ptr = (g + 1) % WAYS;
    end
    m_full = acc ? 1'b1 : (load ? 1'b0 : m_full);
  endtask

  // Apply one cycle of stimulus; returns 3 time units after the rising edge.
  task automatic cycle(input logic [3:0] v, input logic [31:0] d,
                       input logic [3:0] e, input logic r);
    @(posedge clk);
    if (pend_ok) begin
      q.push_back(pend);
      pend_ok = 0;
    end
    #2;
    din_v  = v;
    din_d  = d;
    din_e  = e;
    dout_r = r;
    #1;
    model_step();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    din_v  = '0;
    din_d  = '0;
    din_e  = '0;
    dout_r = 1'b0;
    pend_ok = 0;
    q.delete();
    m_ptr  = 0;
    m_full = 0;
`ifdef BASE_RRARB_LOCK_EN
    m_lock  = 0;
    m_owner = 0;
`endif
    #1;
    check("rst_async_dout_v", 32'(dout_v), 32'd0);
    @(posedge clk);
    #3;
    check("rst_dout_d", 32'(dout_d), 32'd0);
    check("rst_dout_e", 32'(dout_e), 32'd0);
    check("rst_dout_s", 32'(dout_s), 32'd0);
    check("rst_din_r", 32'(din_r), 32'd0);
    reset = 1'b0;
  endtask

  // Monitor: compare the presented beat with the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      check("dout_v", 32'(dout_v), 32'(q.size() != 0));
      if (dout_v && q.size() != 0) begin
        check("dout_beat", 32'({dout_s, dout_e, dout_d}), 32'(q[0]));
        if (dout_r) void'(q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  localparam logic [31:0] LANES = 32'h44332211;

  initial begin
    logic [3:0] e1;
    int exp_s[4];
    logic [W-1:0] held_d;
    logic [1:0]   held_s;

    do_reset();

    // Rotation: all valid, single-beat packets, output always drained.
    for (int k = 0; k < 6; k++) begin
      cycle(4'hF, LANES, 4'hF, 1'b1);
      if (k >= 1) begin
        check("rot_v", 32'(dout_v), 32'd1);
        check("rot_s", 32'(dout_s), 32'((k - 1) % 4));
      end
    end

    // Single requester 2, then everyone: pointer must have moved to 3.
    do_reset();
    cycle(4'b0100, 32'h005A0000, 4'hF, 1'b1);
    cycle(4'hF, LANES, 4'hF, 1'b1);
    check("single_v", 32'(dout_v), 32'd1);
    check("single_d", 32'(dout_d), 32'h5A);
    check("single_s", 32'(dout_s), 32'd2);
    check("single_ptr", 32'(din_r), 32'b1000);

    // Back-pressure: held beat stays, no ready while stalled.
    do_reset();
    cycle(4'hF, LANES, 4'hF, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(4'hF, LANES ^ 32'(k * 32'h01010101), 4'hF, 1'b0);
      if (k == 0) begin
        held_d = dout_d;
        held_s = dout_s;
      end
      check("stall_din_r", 32'(din_r), 32'd0);
      check("stall_d", 32'(dout_d), 32'(held_d));
      check("stall_s", 32'(dout_s), 32'(held_s));
    end
    cycle(4'hF, LANES, 4'hF, 1'b1);
    check("unstall_din_r", 32'(din_r), 32'b0010);
    cycle(4'h0, 32'h0, 4'h0, 1'b1);
    check("unstall_s", 32'(dout_s), 32'd1);

    // Packet lock: ptr=1, requesters 0..2 valid, requester 1 sends e=0,0,1.
    do_reset();
    cycle(4'b0001, LANES, 4'hF, 1'b1);
`ifdef BASE_RRARB_LOCK_EN
    exp_s = '{1, 1, 1, 2};
`else
    exp_s = '{1, 2, 0, 1};
`endif
    e1 = 4'b1100;
    for (int k = 0; k < 4; k++) begin
      cycle(4'b0111, LANES + 32'(k), {1'b1, 1'b1, e1[k], 1'b1}, 1'b1);
      check("lock_grant", 32'(din_r), 32'(1 << exp_s[k]));
    end

    // Reset in the middle of requester 3's packet.
    do_reset();
    cycle(4'b1000, LANES, 4'b0000, 1'b1);
    cycle(4'b0000, 32'h0, 4'b0000, 1'b0);
    check("midpkt_held_v", 32'(dout_v), 32'd1);
    do_reset();
    cycle(4'hF, LANES, 4'hF, 1'b1);
    check("midpkt_first_grant", 32'(din_r), 32'b0001);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      cycle(4'($urandom), $urandom, 4'($urandom | $urandom), ($urandom_range(0, 3) != 0));
    end

    // Drain.
    for (int k = 0; k < 3; k++) cycle(4'h0, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    #1;
    check("drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/base_rrarb.md
BASE_RRARB -- requirements
Module: base_rrarb

Interface
REQ-001 The block SHALL have parameter ways, default 4, meaning the number of requesting input streams (1..16).
REQ-002 The block SHALL have parameter width, default 8, meaning the data bits per beat.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port din_v  input  ways  per-requester valid.
REQ-006 The block SHALL have port din_r  output  ways  per-requester ready.
REQ-007 The block SHALL have port din_d  input  ways*width  requester data; requester i occupies bits [i*width +: width].
REQ-008 The block SHALL have port din_e  input  ways  per-requester end-of-packet flag.
REQ-009 The block SHALL have port dout_v  output  1  output valid.
REQ-010 The block SHALL have port dout_r  input  1  output ready from the consumer.
REQ-011 The block SHALL have port dout_d  output  width  output data.
REQ-012 The block SHALL have port dout_e  output  1  end flag of the output beat.
REQ-013 The block SHALL have port dout_s  output  max(1,clog2(ways))  index of the requester that sourced the output beat.

Function
REQ-014 A transfer on input i SHALL occur in a cycle where din_v[i] & din_r[i] are both high, and a transfer on the output in a cycle where dout_v & dout_r are both high.
REQ-015 The output SHALL be a one-entry register stage: it loads when empty or when drained in the same cycle (~dout_v | dout_r), giving one-cycle latency from input transfer to dout_v.
REQ-016 din_r[i] SHALL equal grant[i] & (~dout_v | dout_r), with at most one grant bit high per cycle, and no din_r bit SHALL depend combinationally on din_v of another requester beyond the grant pick.
REQ-017 The grant SHALL go to the first requester with din_v high, searching from round-robin pointer ptr upward and wrapping from ways-1 to 0.
REQ-018 On an accepted beat from requester i that ends arbitration, ptr SHALL become (i+1) mod ways; otherwise ptr SHALL hold.
REQ-019 Loading the output register SHALL capture din_d, din_e and the index of the granted requester into dout_d, dout_e and dout_s.
REQ-020 While dout_v & ~dout_r, dout_d, dout_e and dout_s SHALL hold stable and all din_r SHALL be low.
REQ-021 With no din_v high, no grant SHALL be issued and ptr SHALL hold.
REQ-022 With ways=1, ptr and dout_s SHALL be constant 0 and the block SHALL act as a one-stage pipeline register.

Reset
REQ-023 Reset SHALL asynchronously force dout_v=0, ptr=0, the lock state to IDLE and owner=0; dout_d, dout_e and dout_s SHALL also clear to 0.
REQ-024 Reset asserted mid-packet SHALL discard the held beat and the lock, and the first grant after release SHALL follow the rule with ptr=0.

Configuration
REQ-025 Macro BASE_RRARB_LOCK_EN SHALL select packet locking.
REQ-026 With BASE_RRARB_LOCK_EN defined, a two-state FSM (IDLE, LOCK) SHALL be present: IDLE->LOCK on an accepted beat with din_e=0, recording the owner; LOCK->IDLE on an accepted owner beat with din_e=1; in LOCK only the owner is granted (bubbles when the owner's din_v is low); ptr advances only on the din_e=1 beat.
REQ-027 Without BASE_RRARB_LOCK_EN, arbitration SHALL occur every beat, din_e SHALL only be forwarded to dout_e, and ptr SHALL advance on every accepted beat.

Structure
REQ-028 The lock-state enumeration (IDLE, LOCK) SHALL live in the shared package base_pkg.
REQ-029 The rotating priority pick (din_v, ptr -> one-hot grant, index) SHALL be the sub-module base_rrarb_pick.

Verification
REQ-030 ways=4, width=8, all din_v=1, din_e=1, dout_r=1 -> dout_s sequence 0,1,2,3,0 on consecutive cycles starting one cycle after the first grant.
REQ-031 Only din_v[2]=1 with data 0x5A, din_e=1 -> the next cycle shows dout_v=1, dout_d=0x5A, dout_s=2, and ptr=3.
REQ-032 dout_v=1 with dout_r=0 held for 3 cycles while all din_v=1 -> din_r=0000 throughout and dout_d/dout_s unchanged; on the cycle dout_r=1 a new beat loads.
REQ-033 Macro on: requesters 0, 1 and 2 valid with ptr=1; requester 1 sends din_e=0,0,1 -> dout_s 1,1,1 then 2. Macro off, same stimulus -> dout_s 1,2,0,1.
REQ-034 Macro on: reset pulsed after requester 3's first beat (din_e=0) -> dout_v drops without waiting for a clock edge; after release, with all valid, the first grant is 0.
